// File: rtl/vid_to_axis.sv
// Small first-word-fall-through FIFO; pointers carry one extra bit so full/empty come from their difference.
// Zero read latency; a push while full and a pop while empty are ignored.
module vid_to_axis_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [AW:0]      count;

  assign count   = wr_q - rd_q;
  assign empty_o = (count == '0);
  assign full_o  = (count == FULL_CNT);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o)  wr_q <= wr_q + 1'b1;
      if (pop_i  && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// Parallel RGB video to AXI4-Stream master: tuser on first pixel of frame, tlast on last pixel of line.
// Pixel to tvalid in 2 cycles; tready stalls fill the FIFO, overflow drops the rest of the frame.
module vid_to_axis #(
  parameter int H_ACTIVE   = 480,
  parameter int V_ACTIVE   = 272,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_vs,
  input  logic        vid_hs,
  input  logic        vid_de,
  input  logic [23:0] vid_rgb,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [3:0]  m_axis_tkeep,
  output logic        overflow,
  output logic        line_err,
  output logic [15:0] frame_cnt
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_DROP = 2'd2} state_t;

  localparam logic [10:0] H_L    = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] V_L    = 11'(V_ACTIVE);

  logic        vs_q, de_q, vs_p_q, de_p_q;
  logic [23:0] rgb_q;
  state_t      state_q, state_d, st_cur;
  logic [10:0] x_q, x_d, x_cur;
  logic [10:0] y_q, y_d, y_cur;
  logic        sof_q, sof_d, sof_cur;
  logic        ovf_q, ovf_d;
  logic        lerr_q, lerr_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        vs_rise, de_fall, push, pop;
  logic [25:0] push_dat, fifo_dout;
  logic        fifo_empty, fifo_full;
  logic        unused_hs;

  assign unused_hs = vid_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      vs_p_q  <= 1'b0;
      de_p_q  <= 1'b0;
      rgb_q   <= '0;
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sof_q   <= 1'b0;
      ovf_q   <= 1'b0;
      lerr_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      vs_q    <= vid_vs;
      de_q    <= vid_de;
      vs_p_q  <= vs_q;
      de_p_q  <= de_q;
      rgb_q   <= vid_rgb;
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sof_q   <= sof_d;
      ovf_q   <= ovf_d;
      lerr_q  <= lerr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    vs_rise = vs_q & ~vs_p_q;
    de_fall = de_p_q & ~de_q;
    st_cur  = state_q;
    x_cur   = x_q;
    y_cur   = y_q;
    sof_cur = sof_q;
    ovf_d   = ovf_q;
    lerr_d  = lerr_q;
    fcnt_d  = fcnt_q;
    push    = 1'b0;
    // Frame restart wins over everything else seen in the same registered cycle.
    if (vs_rise) begin
      st_cur  = S_ACTIVE;
      x_cur   = '0;
      y_cur   = '0;
      sof_cur = 1'b1;
      ovf_d   = 1'b0;
      fcnt_d  = fcnt_q + 16'd1;
    end
    state_d = st_cur;
    x_d     = x_cur;
    y_d     = y_cur;
    sof_d   = sof_cur;
    if (st_cur == S_ACTIVE) begin
      if (de_q) begin
        if (x_cur != 11'h7FF) x_d = x_cur + 11'd1;
        if (y_cur < V_L) begin
          if (x_cur < H_L) begin
            // Full is judged on the pre-pop count, so a same-cycle pop does not rescue the pixel.
            if (fifo_full) begin
              state_d = S_DROP;
              ovf_d   = 1'b1;
            end else begin
              push  = 1'b1;
              sof_d = 1'b0;
            end
          end else begin
            lerr_d = 1'b1;
          end
        end
      end else if (de_fall && !vs_rise) begin
        x_d = '0;
        if (y_cur < V_L) begin
          y_d = y_cur + 11'd1;
          if (x_cur != H_L) lerr_d = 1'b1;
        end
      end
    end
    push_dat = {sof_cur, (x_cur == H_LAST), rgb_q};
  end

  vid_to_axis_fifo #(.WIDTH(26), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .din_i   (push_dat),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Payload is gated by valid so the stream reads as all-zero whenever the FIFO is empty.
  assign pop           = !fifo_empty && m_axis_tready;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? 32'h0 : {8'h00, fifo_dout[23:0]};
  assign m_axis_tuser  = !fifo_empty && fifo_dout[25];
  assign m_axis_tlast  = !fifo_empty && fifo_dout[24];
  assign m_axis_tkeep  = 4'hF;
  assign overflow      = ovf_q;
  assign line_err      = lerr_q;
  assign frame_cnt     = fcnt_q;
endmodule

// File: doc/vid_to_axis.md
# vid_to_axis

Video-timing-to-AXI4-Stream bridge: samples a parallel RGB video port (vs/hs/de/rgb, LCD-panel style timing) and emits each active pixel as an AXI4-Stream master beat with frame-start on `tuser` and end-of-line on `tlast`. It is the receive-side counterpart of the LCD output path, for loopback testing and parallel-camera capture into the same stream fabric. A small FIFO absorbs `tready` backpressure. Video cannot be stalled, so overflow drops the rest of the frame and is flagged.

## Interface

- `H_ACTIVE`, 480: active pixels per line.
- `V_ACTIVE`, 272: active lines per frame.
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of 2, ≥ 4.
- `clk` input 1: single clock for the video sampling and the AXI stream.
- `rst` input 1: synchronous, active-high reset.
- `vid_vs` input 1: vertical sync, active high; its rising edge starts a frame.
- `vid_hs` input 1: horizontal sync, active high; informational only, not used for framing.
- `vid_de` input 1: data enable; one pixel per cycle while high.
- `vid_rgb` input 24: pixel data {R,G,B}.
- `m_axis_tdata` output 32: {8'h00, rgb}.
- `m_axis_tvalid` output 1: beat valid.
- `m_axis_tready` input 1: sink ready.
- `m_axis_tuser` output 1: first pixel of frame (x=0, y=0).
- `m_axis_tlast` output 1: pixel x=H_ACTIVE-1.
- `m_axis_tkeep` output 4: constant 4'hF.
- `overflow` output 1: sticky; cleared at the next vs rising edge.
- `line_err` output 1: sticky; a line was short or long. Cleared by `rst` only.
- `frame_cnt` output 16: count of vs rising edges; wraps.

## Operation

- **Input stage:** `vid_vs`, `vid_de` and `vid_rgb` are registered once. Edge detection is done on the registered `vs` and `de` against their previous values.
- **State machine:**
  - IDLE (the reset state): ignores `de`. A vs rising edge moves to ACTIVE.
  - ACTIVE: accepts pixels.
  - DROP: entered on overflow. Discards all pixels. A vs rising edge moves to ACTIVE.
- **On every vs rising edge, in any state:**
  - x ← 0 and y ← 0.
  - `sof` ← 1.
  - `overflow` ← 0.
  - `frame_cnt` increments.
- **Counters:**
  - x is 11 bits. It increments for each `de`-high cycle in ACTIVE.
  - On a `de` falling edge: x ← 0 and y increments, saturating at V_ACTIVE.
- **Pixel acceptance:** a pixel is accepted when the state is ACTIVE, `de`=1, x < H_ACTIVE and y < V_ACTIVE.
  - Each accepted pixel pushes {`sof`, x==H_ACTIVE-1, rgb} into the FIFO.
  - `sof` clears after the first push.
- **Line errors:** `line_err` is set when `de` falls with x ≠ H_ACTIVE, or when `de` is high with x ≥ H_ACTIVE.
  - Excess pixels are discarded.
  - A short line gets no `tlast`.
- **Extra lines:** lines with y ≥ V_ACTIVE are discarded silently.
- **Short frame:** a vs rising edge mid-frame starts the new frame. No `tlast` is injected and no flag is raised.
- **Overflow:** if an accepted pixel arrives while the FIFO count == FIFO_DEPTH, the pixel is dropped, `overflow` ← 1 and the state moves to DROP.
  - Full is judged before any same-cycle pop, so a pop in that cycle does not prevent overflow.
  - Entries already in the FIFO still drain normally.
- **FIFO:** first-word-fall-through.
  - `tvalid` = !empty.
  - A pop occurs when `tvalid` && `tready`.
  - While `tvalid` && !`tready`, `tdata`, `tuser` and `tlast` are held stable.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide; wrap-around of the pointers is exercised in normal operation.

## Timing

- **Reset:** on `rst`, on the next edge all of the following are reset:
  - FIFO emptied.
  - State IDLE.
  - `tvalid`, `tuser`, `tlast`, `tdata`, `overflow`, `line_err` and `frame_cnt` at 0.
  - `tkeep` is 4'hF at all times.
- **Reset mid-frame:** the FIFO contents are discarded and `tvalid` is 0 after the reset edge. The block then waits in IDLE for the next vs rising edge.
- **Latency:** a pixel present on `vid_*` before edge N is registered at N and written to the FIFO at N+1. With the FIFO empty it is on `m_axis_*` with `tvalid`=1 after N+1, i.e. 2 cycles.
- **Throughput:** 1 beat per cycle sustained when `tready`=1.
- **Vs and de together:** a vs rising edge and `de`=1 in the same registered cycle are handled as follows:
  - the frame reset takes priority;
  - the pixel is accepted as x=0, y=0 with `tuser`=1;
  - the state moves to ACTIVE in that same cycle.
- **Overflow timing:** `overflow` is visible the cycle after the dropped pixel is registered.

## Test plan

- **Nominal frame** (H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=8, `tready`=1): vs pulse, then 2 lines of 4 pixels 0x000001..0x000008 → 8 beats. `tuser` only on 0x000001; `tlast` on 0x000004 and 0x000008; `tdata` = 0x00000001 etc.; first beat 2 cycles after its input; `frame_cnt`=1.
- **Backpressure:** same frame with `tready` toggling 1,0,0,1,… → identical beat sequence. Data is stable while stalled, no loss, `overflow`=0.
- **Overflow:** `tready`=0 with 9 pixels into FIFO_DEPTH=8 → `overflow`=1, state DROP, later pixels ignored. Raising `tready` drains exactly 8 beats. The next vs clears `overflow` and the following frame is captured intact.
- **Line errors:** a 3-pixel line → `line_err`=1 and no `tlast` on that line. A 5-pixel line → 4 beats with `tlast` on the 4th, the 5th dropped, and `line_err`=1.
- **Pre-sync and reset:** `de` activity before the first vs → no beats. `rst` asserted mid-frame with 3 entries queued → `tvalid`=0 next cycle and `frame_cnt`=0; no output until the next vs.
- **Wrap:** 300 back-to-back frames with random `tready` → pointer wrap is exercised, a scoreboard matches every pixel, and `frame_cnt`=300.
